// File: rtl/uart_ss_rx_ctrl.sv
// UART receive controller: start-bit detect, mid-bit sampling, LSB-first frame assembly,
// stop-bit check and a valid/ready output stage with frame-error and overrun pulses.
module uart_ss_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CntHalf = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CntFull = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DATA_BITS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic                 rx_meta_q, rx_s_q, rx_d_q;
  logic                 fall;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;

  // Only a fresh high-to-low transition of the synchronised line arms a frame.
  assign fall = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && i_ready) valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          if (!rx_s_q) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s_q) begin
            // A word still pending and not taken this cycle wins over the new one.
            if (!valid_q || i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_ss_rx_ctrl.sv
// Bench for uart_ss_rx_ctrl: frame-level reference model checked every cycle, a table of
// directed frames, hand-written corner sequences and randomized frames with random i_ready.
module tb_uart_ss_rx_ctrl;

  localparam int CPB = 16;
  localparam int DB  = 8;
  // Clock edges from the first edge that captures the low start bit to the stop-bit sample.
  localparam int STOP_LAT = 2 + CPB / 2 + (DB + 1) * CPB;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_rx    = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun;

  always #5 i_clk = ~i_clk;

  uart_ss_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       ok;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         vcnt = 0, fcnt = 0, ocnt = 0;
  logic [7:0] last = 8'h00;
  bit         busy_seen = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // One clock: model the frame outcomes due at this edge and compare outputs at the negedge.
  task automatic tick();
    logic rdy, vb;
    bit   ef, eo;
    ev_t  ev;
    @(posedge i_clk);
    cyc++;
    rdy = i_ready;
    @(negedge i_clk);
    if (i_rst_n) begin
      vb = m_valid;
      ef = 1'b0;
      eo = 1'b0;
      if (vb && rdy) m_valid = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        if (ev.ok) begin
          if (!vb || rdy) begin
            m_valid = 1'b1;
            m_data  = ev.data;
          end else begin
            eo = 1'b1;
          end
        end else begin
          ef = 1'b1;
        end
      end
      check("cycle", o_valid == m_valid && (!m_valid || o_data == m_data) &&
            o_frame_err == ef && o_overrun == eo,
            $sformatf("cyc %0d got v=%b d=%h fe=%b ov=%b, need v=%b d=%h fe=%b ov=%b", cyc,
                      o_valid, o_data, o_frame_err, o_overrun, m_valid, m_data, ef, eo));
      if (o_valid) begin
        vcnt++;
        last = o_data;
      end
      if (o_frame_err) fcnt++;
      if (o_overrun) ocnt++;
      if (o_busy) busy_seen = 1'b1;
    end
    if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    ticks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
    evq.push_back('{at: cyc + 1 + STOP_LAT, data: d, ok: stop});
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop);
    i_rx = 1'b1;
    ticks(gap_bits * CPB);
  endtask

  task automatic assert_reset_and_check(input string name);
    i_rst_n = 1'b0;
    #1;
    check(name, o_data == 8'h00 && !o_valid && !o_busy && !o_frame_err && !o_overrun,
          $sformatf("got d=%h v=%b busy=%b fe=%b ov=%b, need all 0", o_data, o_valid,
                    o_busy, o_frame_err, o_overrun));
    evq.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  vec_t tbl[6];
  int   v0, f0, o0;

  initial begin
    tbl[0] = '{data: 8'hA5, stop: 1'b1, exp_v: 1, exp_f: 0, exp_data: 8'hA5};
    tbl[1] = '{data: 8'h00, stop: 1'b1, exp_v: 1, exp_f: 0, exp_data: 8'h00};
    tbl[2] = '{data: 8'hFF, stop: 1'b1, exp_v: 1, exp_f: 0, exp_data: 8'hFF};
    tbl[3] = '{data: 8'h80, stop: 1'b1, exp_v: 1, exp_f: 0, exp_data: 8'h80};
    tbl[4] = '{data: 8'h01, stop: 1'b0, exp_v: 0, exp_f: 1, exp_data: 8'h00};
    tbl[5] = '{data: 8'h6E, stop: 1'b1, exp_v: 1, exp_f: 0, exp_data: 8'h6E};

    // Reset state and idle line.
    #2;
    assert_reset_and_check("reset_state");
    ticks(3);
    i_rst_n = 1'b1;
    ticks(2);
    busy_seen = 1'b0;
    v0 = vcnt; f0 = fcnt; o0 = ocnt;
    ticks(200);
    check("idle_200", !busy_seen && vcnt == v0 && fcnt == f0 && ocnt == o0 && o_data == 8'h00,
          $sformatf("got busy_seen=%b dv=%0d df=%0d do=%0d d=%h, need 0 0 0 0 00", busy_seen,
                    vcnt - v0, fcnt - f0, ocnt - o0, o_data));

    // Directed frames with i_ready held high: each good word is valid for exactly one cycle.
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v0 = vcnt; f0 = fcnt;
      send_frame(tbl[i].data, tbl[i].stop, 1);
      check("tbl_valid_cycles", vcnt - v0 == tbl[i].exp_v,
            $sformatf("row %0d got %0d, need %0d", i, vcnt - v0, tbl[i].exp_v));
      check("tbl_frame_err", fcnt - f0 == tbl[i].exp_f,
            $sformatf("row %0d got %0d, need %0d", i, fcnt - f0, tbl[i].exp_f));
      if (tbl[i].exp_v != 0)
        check("tbl_data", last == tbl[i].exp_data,
              $sformatf("row %0d got %h, need %h", i, last, tbl[i].exp_data));
    end

    // Short glitch: start aborts silently.
    busy_seen = 1'b0;
    v0 = vcnt; f0 = fcnt;
    i_rx = 1'b0;
    ticks(4);
    i_rx = 1'b1;
    ticks(2 * CPB);
    check("glitch", busy_seen && !o_busy && vcnt == v0 && fcnt == f0,
          $sformatf("got busy_seen=%b busy=%b dv=%0d df=%0d, need 1 0 0 0", busy_seen, o_busy,
                    vcnt - v0, fcnt - f0));

    // Bad stop, line stuck low, then recovery.
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0, 0);
    i_rx = 1'b0;
    ticks(3 * CPB);
    check("stuck_low_idle", !o_busy && vcnt == v0 && fcnt - f0 == 1,
          $sformatf("got busy=%b dv=%0d df=%0d, need 0 0 1", o_busy, vcnt - v0, fcnt - f0));
    i_rx = 1'b1;
    ticks(CPB);
    send_frame(8'h81, 1'b1, 1);
    check("recover_81", last == 8'h81 && vcnt - v0 == 1 && fcnt - f0 == 1,
          $sformatf("got d=%h dv=%0d df=%0d, need 81 1 1", last, vcnt - v0, fcnt - f0));

    // Back-to-back frames with i_ready low: second word overruns.
    i_ready = 1'b0;
    o0 = ocnt;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 1);
    check("overrun_hold", ocnt - o0 == 1 && o_valid && o_data == 8'h11,
          $sformatf("got dov=%0d v=%b d=%h, need 1 1 11", ocnt - o0, o_valid, o_data));
    i_ready = 1'b1;
    tick();
    check("overrun_consume", !o_valid,
          $sformatf("got v=%b, need 0", o_valid));
    ticks(2);

    // Reset during data bit 3 of 0xFF.
    i_rx = 1'b0;
    ticks(CPB);
    i_rx = 1'b1;
    ticks(3 * CPB + CPB / 2);
    check("busy_mid_frame", o_busy, $sformatf("got busy=%b, need 1", o_busy));
    assert_reset_and_check("reset_mid_frame");
    ticks(3);
    i_rst_n = 1'b1;
    busy_seen = 1'b0;
    v0 = vcnt; f0 = fcnt;
    ticks(2 * CPB);
    check("post_reset_quiet", !busy_seen && vcnt == v0 && fcnt == f0,
          $sformatf("got busy_seen=%b dv=%0d df=%0d, need 0 0 0", busy_seen, vcnt - v0,
                    fcnt - f0));
    send_frame(8'h5A, 1'b1, 1);
    check("post_reset_5a", last == 8'h5A && vcnt - v0 == 1 && fcnt == f0,
          $sformatf("got d=%h dv=%0d df=%0d, need 5a 1 0", last, vcnt - v0, fcnt - f0));

    // Randomized frames, stop bits and consumer stalls against the model.
    rand_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [7:0] d;
      logic       stop;
      int         gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop, gap);
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    ticks(4);
    check("drain", evq.size() == 0 && !o_valid,
          $sformatf("got pending=%0d v=%b, need 0 0", evq.size(), o_valid));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
